// File: rtl/uart_tx_sched_if.sv
// Requester-side bundle for uart_tx_sched: per-requester valid/data/lock
// toward the scheduler, one-hot accept strobe and line status back.
interface uart_tx_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ-1:0]    req_ready;
  logic [GW-1:0]      grant_id;
  logic               busy;
  logic               txd;

  // Requesters drive characters and observe the accept strobe and line.
  modport master (
    output req_valid, req_data, req_lock,
    input  req_ready, grant_id, busy, txd
  );

  // The scheduler consumes requests and drives the serial line.
  modport slave (
    input  req_valid, req_data, req_lock,
    output req_ready, grant_id, busy, txd
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin UART transmitter shared by NREQ byte requesters. One character
// is accepted per idle cycle; a requester holding req_lock keeps the line for
// its next character as long as it stays valid.
module uart_tx_sched #(
  parameter int    NREQ   = 4,
  parameter int    DW     = 8,
  parameter int    SW     = 1,
  parameter logic  IDLE   = 1'b1,
  parameter string PARITY = "NONE",
  parameter int    DIV    = 16
) (
  input logic            clk,
  input logic            rst_n,
  uart_tx_sched_if.slave bus
);
  localparam int GW  = $clog2(NREQ);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DW);
  localparam int SCW = (SW > 1) ? $clog2(SW) : 1;
  localparam bit PAR_EN  = (PARITY != "NONE");
  localparam bit PAR_ODD = (PARITY == "ODD");
  localparam logic [CW-1:0]  BAUD_LOAD = CW'(DIV - 1);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(DW - 1);
  localparam logic [SCW-1:0] LAST_STOP = SCW'(SW - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t          state_reg;
  logic [CW-1:0]   baud_reg;
  logic [BW-1:0]   bit_reg;
  logic [SCW-1:0]  stop_reg;
  logic [DW-1:0]   data_reg;
  logic [GW-1:0]   grant_reg;
  logic [GW-1:0]   last_grant_reg;
  logic            lock_reg;
  logic            txd_reg;
  logic            busy_reg;

  logic [2*NREQ-1:0] dbl_valid;
  logic [2*NREQ-1:0] rot_valid;
  logic [GW:0]       rot_amt;
  logic              lock_hit;
  logic              any_valid;
  logic [GW-1:0]     sel_idx;
  int                sel_sum;
  logic [NREQ-1:0]   ready_next;
  logic              par_bit;

  assign par_bit = PAR_ODD ? ~^data_reg : ^data_reg;

  // Pick the first valid requester after last_grant; a held lock wins outright.
  // The valid vector is doubled and rotated so the search never needs a modulo index.
  always_comb begin
    any_valid = |bus.req_valid;
    lock_hit  = lock_reg & bus.req_valid[last_grant_reg];
    dbl_valid = {bus.req_valid, bus.req_valid};
    rot_amt   = {1'b0, last_grant_reg} + 1'b1;
    rot_valid = dbl_valid >> rot_amt;
    sel_sum   = 0;
    sel_idx   = last_grant_reg;
    if (!lock_hit) begin
      // Walk from the far end so the nearest valid requester is assigned last.
      for (int j = NREQ - 1; j >= 0; j--) begin
        if (rot_valid[j]) begin
          sel_sum = int'(rot_amt) + j;
          if (sel_sum >= NREQ) sel_sum = sel_sum - NREQ;
          sel_idx = GW'(sel_sum);
        end
      end
    end
  end

  // Accept strobe is combinational so the grant lands in the requesting cycle.
  always_comb begin
    ready_next = '0;
    if (rst_n && (state_reg == S_IDLE) && any_valid) ready_next[sel_idx] = 1'b1;
  end

  // Frame sequencer: accept, start bit, data LSB first, optional parity, stop bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      baud_reg       <= '0;
      bit_reg        <= '0;
      stop_reg       <= '0;
      data_reg       <= '0;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NREQ - 1);
      lock_reg       <= 1'b0;
      txd_reg        <= IDLE;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (any_valid) begin
            data_reg       <= bus.req_data[sel_idx*DW +: DW];
            grant_reg      <= sel_idx;
            last_grant_reg <= sel_idx;
            lock_reg       <= bus.req_lock[sel_idx];
            baud_reg       <= BAUD_LOAD;
            txd_reg        <= ~IDLE;
            busy_reg       <= 1'b1;
            state_reg      <= S_START;
          end else begin
            // Nobody valid, so the locked requester (if any) has let go.
            lock_reg <= 1'b0;
          end
        end
        S_START: begin
          if (baud_reg == '0) begin
            baud_reg  <= BAUD_LOAD;
            bit_reg   <= '0;
            txd_reg   <= data_reg[0];
            state_reg <= S_DATA;
          end else begin
            baud_reg <= baud_reg - 1'b1;
          end
        end
        S_DATA: begin
          if (baud_reg == '0) begin
            baud_reg <= BAUD_LOAD;
            if (bit_reg == LAST_BIT) begin
              if (PAR_EN) begin
                txd_reg   <= par_bit;
                state_reg <= S_PAR;
              end else begin
                txd_reg   <= IDLE;
                stop_reg  <= '0;
                state_reg <= S_STOP;
              end
            end else begin
              bit_reg <= bit_reg + 1'b1;
              txd_reg <= data_reg[bit_reg + 1'b1];
            end
          end else begin
            baud_reg <= baud_reg - 1'b1;
          end
        end
        S_PAR: begin
          if (baud_reg == '0) begin
            baud_reg  <= BAUD_LOAD;
            stop_reg  <= '0;
            txd_reg   <= IDLE;
            state_reg <= S_STOP;
          end else begin
            baud_reg <= baud_reg - 1'b1;
          end
        end
        S_STOP: begin
          if (baud_reg == '0) begin
            if (stop_reg == LAST_STOP) begin
              busy_reg  <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              stop_reg <= stop_reg + 1'b1;
              baud_reg <= BAUD_LOAD;
            end
          end else begin
            baud_reg <= baud_reg - 1'b1;
          end
        end
        default: begin
          txd_reg   <= IDLE;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_next;
  assign bus.grant_id  = grant_reg;
  assign bus.busy      = busy_reg;
  assign bus.txd       = txd_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: two instances (8-bit EVEN, and 5-bit ODD with two
// stop bits) are compared every cycle against a cycle-count frame model, with
// directed frames and a randomized request phase.
module tb_uart_tx_sched;
  localparam int DIV = 4;
  localparam int NA = 4, DWA = 8, NB = 3, DWB = 5;

  logic clk = 1'b0;
  logic rst_a_n, rst_b_n;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.NREQ(NA), .DW(DWA)) bus_a ();
  uart_tx_sched_if #(.NREQ(NB), .DW(DWB)) bus_b ();

  uart_tx_sched #(.NREQ(NA), .DW(DWA), .SW(1), .IDLE(1'b1), .PARITY("EVEN"), .DIV(DIV))
    dut_a (.clk(clk), .rst_n(rst_a_n), .bus(bus_a));
  uart_tx_sched #(.NREQ(NB), .DW(DWB), .SW(2), .IDLE(1'b1), .PARITY("ODD"), .DIV(DIV))
    dut_b (.clk(clk), .rst_n(rst_b_n), .bus(bus_b));

  int c_n[2]   = '{NA, NB};
  int c_dw[2]  = '{DWA, DWB};
  int c_sw[2]  = '{1, 2};
  int c_odd[2] = '{0, 1};

  // reference model state: elapsed cycles inside the current frame
  bit m_active[2];
  int m_el[2], m_flen[2], m_grant[2], m_last[2];
  bit m_lock[2];
  bit m_bits[2][32];

  // observed line activity
  int obs_id[2][64];
  int obs_cyc[2][64];
  int obs_n[2] = '{0, 0};
  int cur_len[2] = '{0, 0};
  int last_len[2] = '{0, 0};
  logic [31:0] cur_bits[2] = '{32'd0, 32'd0};
  logic [31:0] last_bits[2] = '{32'd0, 32'd0};
  int cyc = 0;

  int n_checks = 0, n_pass = 0;
  int exp_rr[5] = '{0, 1, 2, 3, 0};
  int exp_lk[4] = '{2, 2, 2, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] char_of(input logic [63:0] data, input int idx, input int dw);
    return (data >> (idx * dw)) & ((64'd1 << dw) - 64'd1);
  endfunction

  // Compare one cycle of DUT outputs against the model, then advance the model
  // across the coming rising edge using the inputs present now.
  task automatic model_step(input int d, input logic rst, input logic [7:0] valid,
                            input logic [7:0] lock, input logic [63:0] data,
                            input logic txd, input logic busy, input logic [7:0] ready,
                            input logic [31:0] grant);
    int n, pick, dw, sw;
    logic [63:0] ch;
    logic [7:0] exp_ready;
    n = c_n[d]; dw = c_dw[d]; sw = c_sw[d];
    if (!rst) begin
      check($sformatf("d%0d reset txd", d), 32'(txd), 32'd1);
      check($sformatf("d%0d reset busy", d), 32'(busy), 32'd0);
      check($sformatf("d%0d reset ready", d), 32'(ready), 32'd0);
      check($sformatf("d%0d reset grant", d), grant, 32'd0);
      m_active[d] = 1'b0; m_grant[d] = 0; m_last[d] = n - 1; m_lock[d] = 1'b0;
      return;
    end
    if (m_active[d]) begin
      check($sformatf("d%0d txd el %0d", d, m_el[d]), 32'(txd), 32'(m_bits[d][m_el[d] / DIV]));
      check($sformatf("d%0d busy", d), 32'(busy), 32'd1);
      check($sformatf("d%0d ready in frame", d), 32'(ready), 32'd0);
      check($sformatf("d%0d grant in frame", d), grant, 32'(m_grant[d]));
      m_el[d]++;
      if (m_el[d] == m_flen[d]) m_active[d] = 1'b0;
    end else begin
      pick = -1;
      if (m_lock[d] && valid[m_last[d]]) pick = m_last[d];
      else begin
        for (int k = 1; k <= n; k++) begin
          int i;
          i = (m_last[d] + k) % n;
          if (valid[i] && pick < 0) pick = i;
        end
      end
      exp_ready = (pick >= 0) ? 8'(1 << pick) : 8'd0;
      check($sformatf("d%0d idle txd", d), 32'(txd), 32'd1);
      check($sformatf("d%0d idle busy", d), 32'(busy), 32'd0);
      check($sformatf("d%0d ready", d), 32'(ready), 32'(exp_ready));
      check($sformatf("d%0d idle grant", d), grant, 32'(m_grant[d]));
      if (pick >= 0) begin
        ch = char_of(data, pick, dw);
        m_bits[d][0] = 1'b0;
        for (int b = 0; b < dw; b++) m_bits[d][1 + b] = ch[b];
        m_bits[d][1 + dw] = ($countones(ch) % 2 == 1) ^ (c_odd[d] == 1);
        for (int s = 0; s < sw; s++) m_bits[d][2 + dw + s] = 1'b1;
        m_flen[d] = (2 + dw + sw) * DIV;
        m_el[d] = 0;
        m_active[d] = 1'b1;
        m_grant[d] = pick; m_last[d] = pick; m_lock[d] = lock[pick];
      end else begin
        m_lock[d] = 1'b0;
      end
    end
  endtask

  // Record accepts and the mid-bit samples of each busy period.
  task automatic observe(input int d, input logic busy, input logic txd,
                         input logic [7:0] ready, input logic [63:0] data);
    int idx;
    if (ready != 8'd0) begin
      idx = 0;
      for (int i = 0; i < 8; i++) if (ready[i]) idx = i;
      if (obs_n[d] < 64) begin
        obs_id[d][obs_n[d]] = idx;
        obs_cyc[d][obs_n[d]] = cyc;
        obs_n[d]++;
      end
      $display("dut%0d accept req %0d char 0x%0h cycle %0d", d, idx, char_of(data, idx, c_dw[d]), cyc);
    end
    if (busy === 1'b1) begin
      if ((cur_len[d] % DIV == DIV / 2) && (cur_len[d] / DIV < 32)) cur_bits[d][cur_len[d] / DIV] = txd;
      cur_len[d]++;
    end else if (cur_len[d] > 0) begin
      last_len[d] = cur_len[d]; last_bits[d] = cur_bits[d];
      cur_len[d] = 0; cur_bits[d] = '0;
    end
  endtask

  // Monitor: outputs and inputs are stable at the falling edge.
  always @(negedge clk) begin
    cyc++;
    model_step(0, rst_a_n, 8'(bus_a.req_valid), 8'(bus_a.req_lock), 64'(bus_a.req_data),
               bus_a.txd, bus_a.busy, 8'(bus_a.req_ready), 32'(bus_a.grant_id));
    model_step(1, rst_b_n, 8'(bus_b.req_valid), 8'(bus_b.req_lock), 64'(bus_b.req_data),
               bus_b.txd, bus_b.busy, 8'(bus_b.req_ready), 32'(bus_b.grant_id));
    observe(0, bus_a.busy, bus_a.txd, 8'(bus_a.req_ready), 64'(bus_a.req_data));
    observe(1, bus_b.busy, bus_b.txd, 8'(bus_b.req_ready), 64'(bus_b.req_data));
  end

  task automatic wait_accepts(input int d, input int cnt, input int bound, input string tag);
    for (int k = 0; k < bound; k++) begin
      @(posedge clk);
      if (obs_n[d] >= cnt) break;
    end
    #1;
    check({tag, " accept count"}, 32'(obs_n[d]), 32'(cnt));
  endtask

  task automatic wait_idle(input int d, input int bound, input string tag);
    logic b;
    b = 1'b1;
    for (int k = 0; k < bound && b; k++) begin
      @(negedge clk);
      b = (d == 0) ? bus_a.busy : bus_b.busy;
    end
    check({tag, " idle"}, 32'(b), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d8;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    bus_a.req_valid = '0; bus_a.req_lock = '0; bus_a.req_data = '0;
    bus_b.req_valid = '0; bus_b.req_lock = '0; bus_b.req_data = '0;
    repeat (3) @(posedge clk);
    #1; rst_a_n = 1'b1; rst_b_n = 1'b1;

    // all four valid, no lock: plain rotation starting at requester 0
    obs_n[0] = 0;
    bus_a.req_data = 32'h13121110; bus_a.req_valid = 4'hF;
    wait_accepts(0, 5, 400, "rr4");
    bus_a.req_valid = '0;
    wait_idle(0, 100, "rr4");
    for (int k = 0; k < 5; k++) check($sformatf("rr4 order %0d", k), 32'(obs_id[0][k]), 32'(exp_rr[k]));
    for (int k = 0; k < 4; k++) check($sformatf("rr4 spacing %0d", k), 32'(obs_cyc[0][k+1] - obs_cyc[0][k]), 32'd45);

    // single 0xA5 frame with even parity
    obs_n[0] = 0;
    bus_a.req_data = 32'h000000A5; bus_a.req_valid = 4'h1;
    wait_accepts(0, 1, 60, "a5");
    bus_a.req_valid = '0;
    wait_idle(0, 100, "a5");
    repeat (4) @(posedge clk); #1;
    check("a5 ready pulses", 32'(obs_n[0]), 32'd1);
    check("a5 grant", 32'(obs_id[0][0]), 32'd0);
    check("a5 busy cycles", 32'(last_len[0]), 32'd44);
    check("a5 bits", 32'(last_bits[0][10:0]), 32'(11'b10101001010));

    // requester 2 locks the line for three characters, then lets go
    obs_n[0] = 0;
    bus_a.req_data = $urandom; bus_a.req_lock = 4'b0100; bus_a.req_valid = 4'b0100;
    wait_accepts(0, 1, 60, "lock1");
    bus_a.req_valid = 4'b0111;
    wait_accepts(0, 3, 200, "lock3");
    bus_a.req_valid = 4'b0011;
    wait_accepts(0, 4, 100, "unlock");
    bus_a.req_valid = '0; bus_a.req_lock = '0;
    wait_idle(0, 100, "lock");
    for (int k = 0; k < 4; k++) check($sformatf("lock order %0d", k), 32'(obs_id[0][k]), 32'(exp_lk[k]));

    // 5-bit odd parity, two stop bits
    obs_n[1] = 0;
    bus_b.req_data = 15'h001F; bus_b.req_valid = 3'b001;
    wait_accepts(1, 1, 60, "odd5");
    bus_b.req_valid = '0;
    wait_idle(1, 100, "odd5");
    check("odd5 busy cycles", 32'(last_len[1]), 32'd36);
    check("odd5 bits", 32'(last_bits[1][8:0]), 32'(9'b110111110));

    // randomized requests on both instances
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 7) == 0) bus_a.req_valid = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus_a.req_lock = 4'($urandom);
      if ($urandom_range(0, 3) == 0) bus_a.req_data = 32'($urandom);
      if ($urandom_range(0, 7) == 0) bus_b.req_valid = 3'($urandom);
      if ($urandom_range(0, 7) == 0) bus_b.req_lock = 3'($urandom);
      if ($urandom_range(0, 3) == 0) bus_b.req_data = 15'($urandom);
    end
    bus_a.req_valid = '0; bus_a.req_lock = '0;
    bus_b.req_valid = '0; bus_b.req_lock = '0;
    wait_idle(0, 100, "rand a");
    wait_idle(1, 100, "rand b");

    // reset during data bit 3 drops the frame; requester 1 goes first afterwards
    obs_n[0] = 0;
    bus_a.req_data = 32'($urandom); bus_a.req_valid = 4'b1000;
    wait_accepts(0, 1, 60, "rst pre");
    bus_a.req_valid = '0;
    repeat (4 * DIV + 1) @(posedge clk);
    #1; rst_a_n = 1'b0;
    #1;
    check("rst mid txd", 32'(bus_a.txd), 32'd1);
    check("rst mid busy", 32'(bus_a.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1; rst_a_n = 1'b1;
    obs_n[0] = 0;
    d8 = 8'($urandom);
    bus_a.req_data = {8'($urandom), 8'($urandom), d8, 8'($urandom)};
    bus_a.req_valid = 4'b0010;
    wait_accepts(0, 1, 60, "rst post");
    bus_a.req_valid = '0;
    wait_idle(0, 100, "rst post");
    check("rst post grant", 32'(obs_id[0][0]), 32'd1);
    check("rst post busy cycles", 32'(last_len[0]), 32'd44);
    check("rst post bits", 32'(last_bits[0][10:0]), 32'({1'b1, ^d8, d8, 1'b0}));

    // 100 quiet cycles: nothing accepted, grant held
    obs_n[0] = 0;
    repeat (100) @(posedge clk);
    #1;
    check("quiet accepts", 32'(obs_n[0]), 32'd0);
    check("quiet grant", 32'(bus_a.grant_id), 32'd1);
    check("quiet txd", 32'(bus_a.txd), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
